// File: rtl/mat_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mat_mult_seq_if
// Description : Operand/result handshake bundle for the sequential NxN
//               matrix multiplier. The master drives operands and consumes
//               results; the slave is the multiplier engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface mat_mult_seq_if #(
  parameter int N      = 3,
  parameter int DATA_W = 16
);
  localparam int MAT_W = N * N * DATA_W;

  logic             in_valid;
  logic             in_ready;
  logic             sat_en;
  logic [MAT_W-1:0] matrix_a_stream;
  logic [MAT_W-1:0] matrix_b_stream;
  logic             out_valid;
  logic             out_ready;
  logic [MAT_W-1:0] matrix_c_stream;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, sat_en, matrix_a_stream, matrix_b_stream, out_ready,
    input  in_ready, out_valid, matrix_c_stream, ovf, busy
  );

  modport slave (
    input  in_valid, sat_en, matrix_a_stream, matrix_b_stream, out_ready,
    output in_ready, out_valid, matrix_c_stream, ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/mat_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : mat_mult_seq
// Description : Time-multiplexed NxN unsigned matrix multiplier, C = A x B.
//               N parallel multipliers feed a summation that yields one C
//               element per cycle. Wrap or saturate output mode with a
//               sticky overflow flag; valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_mult_seq #(
  parameter int N      = 3,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2 * DATA_W + $clog2(N)
) (
  input  wire logic     clk,
  input  wire logic     rst,   // asynchronous, active low
  mat_mult_seq_if.slave bus
);

  localparam int                IDX_W    = $clog2(N);
  localparam int                PROD_W   = 2 * DATA_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
  localparam logic [DATA_W-1:0] MAX_VAL  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  a_q [N][N];
  logic [DATA_W-1:0]  b_q [N][N];
  logic [DATA_W-1:0]  c_q [N][N];
  logic               sat_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [IDX_W-1:0]   i_q;
  logic [IDX_W-1:0]   j_q;

  // Unpacked views of the incoming streams and per-element datapath values
  logic [DATA_W-1:0]  a_in_d [N][N];
  logic [DATA_W-1:0]  b_in_d [N][N];
  logic [PROD_W-1:0]  prod_d [N];
  logic [ACC_W-1:0]   dot_d;
  logic               elem_ovf_d;
  logic [DATA_W-1:0]  elem_d;

  // Row-major packing: element (r,c) sits at slot N*N-1-(r*N+c), so (0,0) is at the MSBs
  generate
    for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
        localparam int OFS = (N * N - 1 - (r * N + c)) * DATA_W;
        assign a_in_d[r][c]                        = bus.matrix_a_stream[OFS +: DATA_W];
        assign b_in_d[r][c]                        = bus.matrix_b_stream[OFS +: DATA_W];
        assign bus.matrix_c_stream[OFS +: DATA_W]  = c_q[r][c];
      end
    end
  endgenerate

  // One multiplier per k term of the current dot product
  generate
    for (genvar k = 0; k < N; k++) begin : g_mul
      assign prod_d[k] = PROD_W'(a_q[i_q][k]) * PROD_W'(b_q[k][j_q]);
    end
  endgenerate

  // Sum the N products at full accumulator width, then apply wrap/saturate
  always_comb begin
    dot_d = '0;
    for (int k = 0; k < N; k++) begin
      dot_d = dot_d + ACC_W'(prod_d[k]);
    end
    elem_ovf_d = |dot_d[ACC_W-1:DATA_W];
    elem_d     = (sat_q && elem_ovf_d) ? MAX_VAL : dot_d[DATA_W-1:0];
  end

  // Control FSM with registered handshake outputs; walks C in row-major order
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sat_q       <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          c_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                a_q[r][c] <= a_in_d[r][c];
                b_q[r][c] <= b_in_d[r][c];
                c_q[r][c] <= '0;
              end
            end
            sat_q      <= bus.sat_en;
            ovf_q      <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= COMPUTE;
          end
        end

        COMPUTE: begin
          c_q[i_q][j_q] <= elem_d;
          ovf_q         <= ovf_q | elem_ovf_d;
          if (j_q == LAST_IDX) begin
            j_q <= '0;
            if (i_q == LAST_IDX) begin
              i_q         <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end

        DONE: begin
          // Result and ovf hold until the consumer takes them
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_mult_seq
// Description : Directed self-checking bench for mat_mult_seq (N=3, 16-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_mult_seq;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int W  = N * N * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mat_mult_seq_if #(.N(N), .DATA_W(DW)) mm_if ();

  mat_mult_seq #(.N(N), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mm_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_ident, m_seq, m_two, m_three, m_five, m_ffff;
  logic [W-1:0] m_18, m_3;
  logic [159:0] junk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer operands, wait for acceptance, then scramble the inputs
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sat);
    int n;
    mm_if.matrix_a_stream = a;
    mm_if.matrix_b_stream = b;
    mm_if.sat_en          = sat;
    mm_if.in_valid        = 1'b1;
    n = 0;
    while (!mm_if.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", W'(mm_if.in_ready), W'(1));
    @(posedge clk); #1;
    mm_if.in_valid = 1'b0;
    junk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    mm_if.matrix_a_stream = junk[W-1:0];
    mm_if.matrix_b_stream = ~junk[W-1:0];
    mm_if.sat_en          = ~sat;
    chk("busy_after_accept", W'(mm_if.busy), W'(1));
  endtask

  // Called right after the acceptance edge: check latency and result
  task automatic wait_done(input string tag, input logic [W-1:0] exp_c, input logic exp_ovf);
    int lat;
    lat = 0;
    while (!mm_if.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, W'(lat), W'(9));
    chk({tag, "_c"}, mm_if.matrix_c_stream, exp_c);
    chk({tag, "_ovf"}, W'(mm_if.ovf), W'(exp_ovf));
  endtask

  task automatic handoff(input string tag);
    mm_if.out_ready = 1'b1;
    @(posedge clk); #1;
    mm_if.out_ready = 1'b0;
    chk({tag, "_ov_drop"}, W'(mm_if.out_valid), W'(0));
    chk({tag, "_ready_back"}, W'(mm_if.in_ready), W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, res_n, cyc;
    int acc_cyc [2];
    logic pre;

    m_ident = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
    m_seq   = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    m_two   = {9{16'd2}};
    m_three = {9{16'd3}};
    m_five  = {9{16'd5}};
    m_ffff  = {9{16'hFFFF}};
    m_18    = {9{16'h0012}};
    m_3     = {9{16'h0003}};

    mm_if.in_valid        = 1'b0;
    mm_if.out_ready       = 1'b0;
    mm_if.sat_en          = 1'b0;
    mm_if.matrix_a_stream = '0;
    mm_if.matrix_b_stream = '0;

    // Reset values
    #12;
    chk("rst_in_ready", W'(mm_if.in_ready), W'(1));
    chk("rst_out_valid", W'(mm_if.out_valid), W'(0));
    chk("rst_busy", W'(mm_if.busy), W'(0));
    chk("rst_ovf", W'(mm_if.ovf), W'(0));
    chk("rst_c", mm_if.matrix_c_stream, W'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Identity x 1..9
    start_op(m_ident, m_seq, 1'b0);
    wait_done("ident", m_seq, 1'b0);
    handoff("ident");

    // All 2 x all 3 -> 18
    start_op(m_two, m_three, 1'b0);
    wait_done("twos", m_18, 1'b0);

    // Backpressure: hold result with new operands offered
    mm_if.matrix_a_stream = m_ident;
    mm_if.matrix_b_stream = m_five;
    mm_if.sat_en          = 1'b0;
    mm_if.in_valid        = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk("bp_c", mm_if.matrix_c_stream, m_18);
      chk("bp_ovf", W'(mm_if.ovf), W'(0));
      chk("bp_in_ready", W'(mm_if.in_ready), W'(0));
      chk("bp_out_valid", W'(mm_if.out_valid), W'(1));
    end
    handoff("bp");
    @(posedge clk); #1;
    chk("bp_new_accept_busy", W'(mm_if.busy), W'(1));
    chk("bp_new_accept_ready", W'(mm_if.in_ready), W'(0));
    mm_if.in_valid = 1'b0;
    wait_done("bp_new", m_five, 1'b0);
    handoff("bp_new");

    // Saturate and wrap on all-ones operands
    start_op(m_ffff, m_ffff, 1'b1);
    wait_done("sat", m_ffff, 1'b1);
    handoff("sat");
    start_op(m_ffff, m_ffff, 1'b0);
    wait_done("wrap", m_3, 1'b1);
    handoff("wrap");

    // Reset in the 4th COMPUTE cycle
    start_op(m_ffff, m_ffff, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_ovf", W'(mm_if.ovf), W'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", W'(mm_if.out_valid), W'(0));
    chk("mid_rst_busy", W'(mm_if.busy), W'(0));
    chk("mid_rst_ovf", W'(mm_if.ovf), W'(0));
    chk("mid_rst_c", mm_if.matrix_c_stream, W'(0));
    chk("mid_rst_in_ready", W'(mm_if.in_ready), W'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", W'(mm_if.in_ready), W'(1));
    chk("post_rst_out_valid", W'(mm_if.out_valid), W'(0));
    start_op(m_ident, m_seq, 1'b0);
    wait_done("post_rst", m_seq, 1'b0);
    handoff("post_rst");

    // Back-to-back with out_ready held high
    mm_if.out_ready       = 1'b1;
    mm_if.matrix_a_stream = m_two;
    mm_if.matrix_b_stream = m_three;
    mm_if.sat_en          = 1'b0;
    mm_if.in_valid        = 1'b1;
    acc_n = 0;
    res_n = 0;
    cyc   = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    for (int t = 0; t < 40 && res_n < 2; t++) begin
      if (mm_if.out_valid) begin
        chk("b2b_c", mm_if.matrix_c_stream, (res_n == 0) ? m_18 : m_seq);
        chk("b2b_ovf", W'(mm_if.ovf), W'(0));
        res_n++;
      end
      pre = mm_if.in_valid && mm_if.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (pre && acc_n < 2) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) begin
          mm_if.matrix_a_stream = m_seq;
          mm_if.matrix_b_stream = m_ident;
        end else begin
          mm_if.in_valid = 1'b0;
        end
      end
    end
    mm_if.out_ready = 1'b0;
    chk("b2b_results", W'(res_n), W'(2));
    chk("b2b_accepts", W'(acc_n), W'(2));
    chk("b2b_gap", W'(acc_cyc[1] - acc_cyc[0]), W'(11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mat_mult_seq.md
Name: mat_mult_seq

Overview:
Parametrised NxN unsigned matrix multiplier, C = A x B, for the benchmark datapath. It replaces the fixed 3x3 single-cycle multiplier with a time-multiplexed engine. N parallel multipliers and an adder tree produce one C element per cycle. Valid/ready handshakes on input and output, plus a selectable wrap or saturate output mode with a sticky overflow flag.

Parameters:
N, 3, matrix dimension (N >= 2).
DATA_W, 16, width of every A, B and C element, unsigned.
ACC_W, 2*DATA_W+$clog2(N), internal dot-product width; never overflows.

Ports:
clk  in  1  system clock, 100 MHz.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  A/B operands valid.
in_ready  out  1  block can accept operands.
sat_en  in  1  output mode, sampled at acceptance: 1 = saturate, 0 = wrap (keep low DATA_W bits).
matrix_a_stream  in  N*N*DATA_W  A packed row-major; element (r,c) at [(N*N-1-(r*N+c))*DATA_W +: DATA_W], so (0,0) is at the MSBs.
matrix_b_stream  in  N*N*DATA_W  B, same packing.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
matrix_c_stream  out  N*N*DATA_W  C, same packing.
ovf  out  1  at least one element of the current result exceeded 2^DATA_W-1.
busy  out  1  high in COMPUTE and DONE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; in_ready=1; out_valid=0; busy=0; ovf=0; matrix_c_stream=0; operand registers and indices cleared. Reset during COMPUTE or DONE aborts the operation; no partial result is presented.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE: in_ready=1. On in_valid && in_ready at edge E0:
  - capture A, B and sat_en into internal registers;
  - clear the C register and ovf;
  - set i=0, j=0;
  - go to COMPUTE.
- COMPUTE: in_ready=0, busy=1. Each edge:
  - compute dot = sum over k of A[i][k]*B[k][j] in ACC_W bits;
  - write C[i][j] = (sat_en_q && dot > 2^DATA_W-1) ? 2^DATA_W-1 : dot[DATA_W-1:0];
  - set ovf |= (dot > 2^DATA_W-1), in both modes;
  - advance j; when j wraps from N-1 to 0, increment i.
  - After edge E(N*N), which writes element (N-1,N-1), go to DONE.
- DONE: out_valid=1; matrix_c_stream and ovf hold stable. On out_valid && out_ready, go to IDLE and drop out_valid the next cycle. in_valid is ignored until IDLE.
- Latency: out_valid is first high in the cycle after edge E(N*N), i.e. N*N cycles after acceptance (9 for N=3).
- Throughput: one matrix per N*N+2 cycles minimum (acceptance edge, N*N compute edges, handoff edge).
- matrix_c_stream holds the previous result, or 0 after reset, until the next DONE. During COMPUTE it is undefined to the consumer; only the value with out_valid is contractual.
- Operand inputs may change freely after acceptance; only the captured copies are used.
- Multiply and add are unsigned. ACC_W is sized so the internal sum never overflows.

Test Plan:
- N=3, A=identity, B=1..9 row-major, sat_en=0 -> C=1..9, ovf=0, out_valid first high exactly 9 cycles after the acceptance edge.
- N=3, all A=2, all B=3 -> every C element =18 (0x0012), ovf=0.
- N=3, all A=B=0xFFFF, sat_en=1 -> every C element =0xFFFF, ovf=1. Same operands, sat_en=0 -> every element =0x0003 (low 16 bits of 0x2FFFA0003), ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> result and ovf stable, in_ready=0, new operands not accepted. After out_ready=1 -> back to IDLE, new operands accepted the following cycle.
- Reset mid-operation: assert rst low at the 4th COMPUTE cycle -> all outputs 0 immediately, in_ready=1 after release; a fresh operation then produces the correct result.
- Back-to-back: two operand sets offered with out_ready=1 throughout -> both results correct and in order, acceptance edges 11 cycles apart for N=3.
